// File: rtl/wide_add_seq_pkg.sv
// Shared constants and FSM state encoding
// for the multi-word add/subtract sequencer.
package wide_add_pkg;

   localparam int WORD_W    = 32;
   localparam int MAX_WORDS = 16;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

endpackage

// File: rtl/wide_add_seq_if.sv
// Operand request and result handshake bundle
// between the ALU operand stage and writeback.
interface wide_add_seq_if #(
   parameter int WORDS = 4
);
   import wide_add_pkg::*;

   localparam int W = WORD_W * WORDS;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;

   modport master (
      output in_valid,
      output in_a,
      output in_b,
      output in_sub,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_sum,
      input  out_cout,
      input  out_ovf
   );

   modport slave (
      input  in_valid,
      input  in_a,
      input  in_b,
      input  in_sub,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_sum,
      output out_cout,
      output out_ovf
   );

endinterface

// File: rtl/wide_add_seq_adder.sv
// 32-bit ripple-carry adder: the single
// arithmetic datapath reused for every word.
module ripple_adder
   import wide_add_pkg::*;
(
   input  logic [WORD_W-1:0] a_i,
   input  logic [WORD_W-1:0] b_i,
   input  logic              cin_i,
   output logic [WORD_W-1:0] sum_o,
   output logic              cout_o
);

   logic [WORD_W:0] c;

   // Bit-serial carry chain, LSB to MSB
   always_comb begin
      c     = '0;
      sum_o = '0;
      c[0]  = cin_i;
      for (int i = 0; i < WORD_W; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
         c[i+1]   = (a_i[i] & b_i[i])
                  | (a_i[i] & c[i])
                  | (b_i[i] & c[i]);
      end
      cout_o = c[WORD_W];
   end

endmodule

// File: rtl/wide_add_seq.sv
// Multi-word add/sub sequencer, one word per cycle, LSW first.
// Optional WIDE_ADD_OVF_EN enables signed overflow output.
module wide_add_seq
   import wide_add_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   wide_add_seq_if.slave bus
);

   localparam int W  = WORD_W * WORDS;
   localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

   state_t        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic          carry_q, carry_d;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic          sub_q;
   logic [W-1:0]  sum_q;
   logic          cout_q;

   logic [WORD_W-1:0] add_a;
   logic [WORD_W-1:0] add_b;
   logic [WORD_W-1:0] add_sum;
   logic              add_cout;
   logic              accept;
   logic              last;

   assign accept = bus.in_valid && (state_q == IDLE);
   assign last   = (state_q == RUN) && (k_q == K_LAST);

   // Word-select mux feeding the shared adder
   always_comb begin
      add_a = a_q[k_q*WORD_W +: WORD_W];
      add_b = b_q[k_q*WORD_W +: WORD_W];
      if (sub_q) begin
         add_b = ~add_b;
      end
   end

   ripple_adder u_adder (
      .a_i    (add_a),
      .b_i    (add_b),
      .cin_i  (carry_q),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   // Next-state logic for FSM, word counter and carry
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      carry_d = carry_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = RUN;
               k_d     = '0;
               carry_d = bus.in_sub;
            end
         end
         RUN: begin
            carry_d = add_cout;
            if (last) begin
               state_d = DONE;
               k_d     = '0;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            k_d     = '0;
         end
      endcase
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         carry_q <= carry_d;
      end
   end

   // Operand capture on request acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         sub_q <= 1'b0;
      end else if (accept) begin
         a_q   <= bus.in_a;
         b_q   <= bus.in_b;
         sub_q <= bus.in_sub;
      end
   end

   // Result words fill in as RUN walks the counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else if (state_q == RUN) begin
         sum_q[k_q*WORD_W +: WORD_W] <= add_sum;
         if (last) begin
            cout_q <= add_cout;
         end
      end
   end

`ifdef WIDE_ADD_OVF_EN
   logic ovf_q;

   // Signed overflow taken from the top word's MSBs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (last) begin
         ovf_q <= (add_a[WORD_W-1] == add_b[WORD_W-1])
               && (add_sum[WORD_W-1] != add_a[WORD_W-1]);
      end
   end

   assign bus.out_ovf = ovf_q;
`else
   assign bus.out_ovf = 1'b0;
`endif

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_sum   = sum_q;
   assign bus.out_cout  = cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed self-checking bench for wide_add_seq
// (WORDS = 4), with or without WIDE_ADD_OVF_EN.
module tb_wide_add_seq;

   localparam int WORDS = 4;
   localparam int W     = 32 * WORDS;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   wide_add_seq_if #(.WORDS(WORDS)) bus ();

   wide_add_seq #(.WORDS(WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef WIDE_ADD_OVF_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   localparam logic [W-1:0] ONES = {W{1'b1}};

   task automatic do_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic sub,
                        output int lat);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_sub   = sub;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic to_idle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs: ready=%b valid=%b need 1/0",
                  bus.in_ready, bus.out_valid);
      end
      checks++;
      if (bus.out_sum !== '0 || bus.out_cout !== 1'b0
          || bus.out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: sum=%h c=%b o=%b need 0",
                  bus.out_sum, bus.out_cout, bus.out_ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add_carry();
      int lat;
      do_op(128'h0000_0000_FFFF_FFFF, 128'h1, 1'b0, lat);
      checks++;
      if (lat !== WORDS) begin
         errors++;
         $display("FAIL add_lat: got %0d need %0d", lat, WORDS);
      end
      checks++;
      if (bus.out_sum !== 128'h1_0000_0000 || bus.out_cout !== 1'b0) begin
         errors++;
         $display("FAIL add_carry: sum=%h c=%b need 100000000/0",
                  bus.out_sum, bus.out_cout);
      end
      to_idle();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_exit: ready=%b valid=%b need 1/0",
                  bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_add_wrap();
      int lat;
      do_op(ONES, 128'h1, 1'b0, lat);
      checks++;
      if (lat !== WORDS || bus.out_sum !== '0 || bus.out_cout !== 1'b1
          || bus.out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL add_wrap: lat=%0d sum=%h c=%b o=%b need 4/0/1/0",
                  lat, bus.out_sum, bus.out_cout, bus.out_ovf);
      end
      to_idle();
   endtask

   task automatic test_sub();
      int lat;
      do_op(128'h5, 128'h7, 1'b1, lat);
      checks++;
      if (lat !== WORDS || bus.out_sum !== {ONES[W-1:1], 1'b0}
          || bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL sub_borrow: lat=%0d sum=%h c=%b o=%b",
                  lat, bus.out_sum, bus.out_cout, bus.out_ovf);
      end
      to_idle();
      do_op(128'h7, 128'h5, 1'b1, lat);
      checks++;
      if (lat !== WORDS || bus.out_sum !== 128'h2
          || bus.out_cout !== 1'b1 || bus.out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL sub_pos: lat=%0d sum=%h c=%b o=%b need 4/2/1/0",
                  lat, bus.out_sum, bus.out_cout, bus.out_ovf);
      end
      to_idle();
   endtask

   task automatic test_ovf();
      int lat;
      do_op({1'b0, ONES[W-2:0]}, 128'h1, 1'b0, lat);
      checks++;
      if (lat !== WORDS || bus.out_sum !== {1'b1, {(W-1){1'b0}}}
          || bus.out_cout !== 1'b0) begin
         errors++;
         $display("FAIL ovf_sum: lat=%0d sum=%h c=%b", lat,
                  bus.out_sum, bus.out_cout);
      end
      checks++;
      if (bus.out_ovf !== OVF_EXP) begin
         errors++;
         $display("FAIL ovf_flag: got %b need %b", bus.out_ovf, OVF_EXP);
      end
      to_idle();
   endtask

   task automatic test_backpressure();
      int lat;
      bit bad;
      bus.out_ready = 1'b0;
      do_op(128'h3_0000_0000_0000_0000, 128'h4, 1'b0, lat);
      checks++;
      if (lat !== WORDS) begin
         errors++;
         $display("FAIL bp_lat: got %0d need %0d", lat, WORDS);
      end
      bad = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = 128'h9;
      bus.in_b     = 128'h9;
      bus.in_sub   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0
             || bus.out_sum !== 128'h3_0000_0000_0000_0004
             || bus.out_cout !== 1'b0)
            bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL bp_hold: valid=%b ready=%b sum=%h need 1/0/3..4",
                  bus.out_valid, bus.in_ready, bus.out_sum);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_exit: ready=%b valid=%b need 1/0",
                  bus.in_ready, bus.out_valid);
      end
      bus.in_a = 128'd100;
      bus.in_b = 128'd1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_accept: ready=%b need 0", bus.in_ready);
      end
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            lat = i;
            break;
         end
      end
      checks++;
      if (lat !== WORDS || bus.out_sum !== 128'd101) begin
         errors++;
         $display("FAIL bp_next: lat=%0d sum=%h need 4/65",
                  lat, bus.out_sum);
      end
      to_idle();
   endtask

   task automatic test_reset_midrun();
      int  lat;
      bit  seen;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = ONES;
      bus.in_b     = ONES;
      bus.in_sub   = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0
          || bus.out_sum !== '0) begin
         errors++;
         $display("FAIL rst_mid: ready=%b valid=%b sum=%h need 1/0/0",
                  bus.in_ready, bus.out_valid, bus.out_sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL rst_novalid: got valid=1 need 0");
      end
      do_op(128'h7, 128'h5, 1'b1, lat);
      checks++;
      if (lat !== WORDS || bus.out_sum !== 128'h2
          || bus.out_cout !== 1'b1) begin
         errors++;
         $display("FAIL rst_after: lat=%0d sum=%h c=%b need 4/2/1",
                  lat, bus.out_sum, bus.out_cout);
      end
      to_idle();
   endtask

   task automatic test_back_to_back();
      int t0;
      int t1;
      int n;
      t0 = -1;
      t1 = -1;
      n  = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = 128'h1_0000_0001;
      bus.in_b     = 128'h2_0000_0002;
      bus.in_sub   = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            if (bus.out_sum !== 128'h3_0000_0003) n = -100;
            if (t0 < 0) begin
               t0 = i;
            end else begin
               t1 = i;
               bus.in_valid = 1'b0;
               break;
            end
         end
      end
      bus.in_valid = 1'b0;
      checks++;
      if (t1 - t0 !== WORDS + 2 || t0 < 0 || t1 < 0) begin
         errors++;
         $display("FAIL b2b_gap: got %0d need %0d", t1 - t0, WORDS + 2);
      end
      checks++;
      if (n !== 0) begin
         errors++;
         $display("FAIL b2b_sum: a result differed from 300000003");
      end
      to_idle();
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_sub    = 1'b0;
      bus.out_ready = 1'b1;
      test_reset();
      test_add_carry();
      test_add_wrap();
      test_sub();
      test_ovf();
      test_backpressure();
      test_reset_midrun();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Multi-word add/subtract sequencer around the single 32-bit ripple adder datapath. It accepts two WORDS×32-bit operands through a valid/ready handshake and streams them one 32-bit word per cycle, LSW first, through one adder instance, chaining the carry in a register. It presents the full-width result through a second valid/ready handshake. It sits between the ALU operand registers and the result writeback stage, so that wide arithmetic reuses the one adder.

## Interface
- WORDS, 4, number of 32-bit words per operand; legal range 1..16; total width W = 32*WORDS
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and opcode valid
- in_ready  out  1  sequencer can accept; combinational, equals (state == IDLE)
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_sub  in  1  0 = A+B, 1 = A−B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  W  result, registered
- out_cout  out  1  final carry out; for subtract, 1 means no borrow
- out_ovf  out  1  signed overflow of the W-bit result; see Configuration

## Operation
- FSM states:
  - IDLE → RUN on in_valid && in_ready.
  - RUN → DONE after the word counter reaches WORDS−1.
  - DONE → IDLE on out_ready.
- On accept:
  - latch in_a, in_b and in_sub into operand registers
  - set the word counter k = 0
  - set the carry register = in_sub
- Each RUN cycle:
  - adder inputs: A = a[k], B = in_sub ? ~b[k] : b[k], Cin = carry register
  - write the adder Sum into out_sum word k
  - load the adder Cout into the carry register
  - increment k
- On the last RUN cycle, out_cout is loaded with the adder Cout.
- DONE: out_valid = 1. out_sum and out_cout hold stable until the handshake completes.
- in_valid, in_a, in_b and in_sub are ignored outside IDLE. Only one operation is in flight at a time.
- No early termination. Every operation takes exactly WORDS RUN cycles regardless of operand values.
- out_sum retains the last result after the DONE→IDLE transition. Words of out_sum are overwritten progressively during the next RUN.

## Timing
- Reset (rst_n low) gives:
  - state IDLE, so in_ready = 1
  - out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0
  - carry register = 0, k = 0
- Latency: handshake at edge e0. RUN occupies cycles e0+1 … e0+WORDS. out_valid rises at edge e0+WORDS.
- With out_ready held high, out_valid is high for exactly one cycle. in_ready returns high on the following cycle.
- Throughput is one operation per WORDS+2 cycles when out_ready is held high.
- in_ready is low in RUN and DONE. A new request presented in DONE, even with out_ready = 1, is accepted no earlier than the next cycle in IDLE.
- WORDS = 1: RUN lasts a single cycle. The counter is 1 bit wide minimum.
- Reset mid-RUN or in DONE: asynchronous return to reset values. The partial result is discarded and no out_valid is produced.

## Configuration
- WIDE_ADD_OVF_EN defined:
  - out_ovf is registered on the last RUN cycle.
  - out_ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the inverted-if-subtract B.
  - out_ovf holds with out_sum.
- WIDE_ADD_OVF_EN not defined:
  - the port remains and is tied to 0
  - no overflow logic is generated

## Structure
- Package wide_add_pkg holds:
  - WORD_W = 32
  - MAX_WORDS = 16
  - the FSM state typedef (IDLE, RUN, DONE)
- One sub-module: a single instance of the existing 32-bit ripple_adder, driven from the word-select mux. No other arithmetic in this block.

## Test plan
- WORDS=4, A = 0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, B = 1, add → out_sum = 0x…0001_0000_0000, out_cout = 0, out_valid at handshake+4 cycles.
- WORDS=4, A = all-ones, B = 1, add → out_sum = 0, out_cout = 1; with WIDE_ADD_OVF_EN, out_ovf = 0.
- WORDS=4, A = 5, B = 7, sub → out_sum = 0xFFFF…FFFE, out_cout = 0 (borrow). A = 7, B = 5, sub → out_sum = 2, out_cout = 1.
- WIDE_ADD_OVF_EN, A = 0x7FFF…FFFF, B = 1, add → out_sum = 0x8000…0000, out_ovf = 1; without the macro, out_ovf = 0.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE → out_valid, out_sum and out_cout stable, in_ready = 0, a new in_valid is ignored; release → the next operation is accepted one cycle after DONE exit.
- Assert rst_n low on RUN cycle 2 → immediate in_ready = 1, out_valid = 0, out_sum = 0; a subsequent op completes with the correct result.
